// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and helpers for the register write-port arbiter.
// Optional statistics counters are enabled with REG_ARB_STATS_EN.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Only meaningful when at least one request is high.
  function automatic logic next_owner(
    input logic req0,
    input logic req1,
    input logic last
  );
    if (req0 && !req1) return REQ0;
    if (req1 && !req0) return REQ1;
    return ~last;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Request/acknowledge and Mux/Register control bundle.
// Statistics ports (REG_ARB_STATS_EN) stay on the top module.
interface reg_share_arbiter_if;

  logic       req0;
  logic       req1;
  logic       ack0;
  logic       ack1;
  logic       mux_sel;
  logic       reg_write_en;
  logic [1:0] grant;

  modport slave (
    input  req0,
    input  req1,
    output ack0,
    output ack1,
    output mux_sel,
    output reg_write_en,
    output grant
  );

  modport master (
    output req0,
    output req1,
    input  ack0,
    input  ack1,
    input  mux_sel,
    input  reg_write_en,
    input  grant
  );

endinterface

// File: rtl/reg_share_arbiter_burst_counter.sv
// Modulo-MAX_BURST beat counter flagging the last beat of a burst.
// Unaffected by REG_ARB_STATS_EN.
module reg_arb_burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);

  localparam logic [7:0] LIMIT = 8'(MAX_BURST - 1);

  logic [7:0] cnt;

  assign at_limit = (cnt == LIMIT);

  // Count beats, wrapping to zero after the limit beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= at_limit ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of a shared Register write port with burst limit.
// Define REG_ARB_STATS_EN to add per-requester transfer counters.
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef REG_ARB_STATS_EN
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
`endif
  reg_share_arbiter_if.slave   bus
);

  arb_state_t state;
  arb_state_t nxt;
  logic       last;
  logic       sel_q;
  logic       xfer0;
  logic       xfer1;
  logic       at_limit;
  logic       enter;

  assign xfer0 = (state == OWN0) && bus.req0;
  assign xfer1 = (state == OWN1) && bus.req1;
  assign enter = (nxt != state) && (nxt != IDLE);

  assign bus.ack0         = xfer0;
  assign bus.ack1         = xfer1;
  assign bus.reg_write_en = xfer0 | xfer1;
  assign bus.mux_sel      = sel_q;
  assign bus.grant        = {state == OWN1, state == OWN0};

  reg_arb_burst_counter #(
    .MAX_BURST(MAX_BURST)
  ) u_burst (
    .clk     (clk),
    .reset   (reset),
    .clear   (enter),
    .inc     (xfer0 | xfer1),
    .at_limit(at_limit)
  );

  // Next owner: drop or burst limit hands over without a bubble.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          nxt = (next_owner(bus.req0, bus.req1, last) == REQ0)
                ? OWN0 : OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          nxt = bus.req1 ? OWN1 : IDLE;
        end else if (at_limit && bus.req1) begin
          nxt = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          nxt = bus.req0 ? OWN0 : IDLE;
        end else if (at_limit && bus.req0) begin
          nxt = OWN0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and a select that holds through IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= REQ1;
      sel_q <= 1'b0;
    end else begin
      state <= nxt;
      if (enter) begin
        last  <= (nxt == OWN1);
        sel_q <= (nxt == OWN0);
      end
    end
  end

`ifdef REG_ARB_STATS_EN
  // Free-running wrap-around transfer counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (xfer0) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
      if (xfer1) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
